// File: rtl/result_pack.sv
// result_pack: packs PACK_NB consecutive result beats from `layers` into one
// wide word for the output memory writer. It counts beats against a configured
// frame length N, zero-pads a final partial word and flags the frame's last
// word. A config write with repeat=1 re-arms the frame automatically.
//
// Build option: define RESULT_PACK_MSB_FIRST_EN to reverse the lane order, so
// beat k lands in lane PACK_NB-1-k and zero padding fills the low lanes.
module result_pack #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 1,
  parameter int IMG_WIDTH  = 16,
  parameter int PACK_NB    = 4,
  parameter logic [CFG_AWIDTH-1:0] CFG_RESULT = CFG_AWIDTH'(12)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CFG_DWIDTH-1:0]                 cfg_data,
  input  logic [CFG_AWIDTH-1:0]                 cfg_addr,
  input  logic                                  cfg_valid,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0]         result_bus,
  input  logic                                  result_val,
  output logic                                  result_rdy,
  output logic [PACK_NB*IMG_WIDTH*DEPTH_NB-1:0] pack_bus,
  output logic                                  pack_last,
  output logic                                  pack_val,
  input  logic                                  pack_rdy
);

  localparam int BEAT_W = IMG_WIDTH * DEPTH_NB;
  localparam int PACK_W = PACK_NB * BEAT_W;
  localparam int K_W    = (PACK_NB > 2) ? $clog2(PACK_NB) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(PACK_NB - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [15:0]         n_r;
  logic                rep_r;
  logic [15:0]         cnt_r;
  logic [K_W-1:0]      k_r;
  logic [PACK_W-1:0]   acc_r;

  logic                cfg_load_s;
  logic                last_beat_s;
  logic                completes_s;
  logic                out_free_s;
  logic                beat_fire_s;
  logic [K_W-1:0]      lane_s;
  logic [PACK_W-1:0]   acc_next_s;
  logic                unused_cfg_s;

  // Only the N and repeat fields of the config word carry meaning here.
  assign unused_cfg_s = ^cfg_data[CFG_DWIDTH-1:17];

  assign cfg_load_s  = cfg_valid && (cfg_addr == CFG_RESULT) &&
                       (cfg_data[15:0] != 16'd0);
  assign last_beat_s = (cnt_r == (n_r - 16'd1));
  assign completes_s = (k_r == K_LAST) || last_beat_s;
  assign out_free_s  = !pack_val || pack_rdy;
  // Only the beat that would push a word into a full output register stalls.
  assign result_rdy  = (state_r == ST_ACTIVE) && (!completes_s || out_free_s);
  assign beat_fire_s = result_val && result_rdy;

`ifdef RESULT_PACK_MSB_FIRST_EN
  assign lane_s = K_LAST - k_r;
`else
  assign lane_s = k_r;
`endif

  // Accumulator image with the incoming beat dropped into its lane.
  always_comb begin
    acc_next_s = acc_r;
    for (int i = 0; i < PACK_NB; i++) begin
      if (lane_s == K_W'(i)) begin
        acc_next_s[i*BEAT_W +: BEAT_W] = result_bus;
      end else begin
        acc_next_s[i*BEAT_W +: BEAT_W] = acc_r[i*BEAT_W +: BEAT_W];
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame sequencing: IDLE waits for a config, ACTIVE takes N beats, DONE
  // spends one cycle after the final word has entered the output register.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_load_s) begin
          state_s = ST_ACTIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (beat_fire_s && last_beat_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_DONE: begin
        if (rep_r) begin
          state_s = ST_ACTIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Frame configuration, beat/lane counters and the lane accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r   <= 16'd0;
      rep_r <= 1'b0;
      cnt_r <= 16'd0;
      k_r   <= '0;
      acc_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_load_s) begin
            n_r   <= cfg_data[15:0];
            rep_r <= cfg_data[16];
            cnt_r <= 16'd0;
            k_r   <= '0;
            acc_r <= '0;
          end
        end
        ST_ACTIVE: begin
          if (beat_fire_s) begin
            cnt_r <= cnt_r + 16'd1;
            if (completes_s) begin
              k_r   <= '0;
              acc_r <= '0;
            end else begin
              k_r   <= k_r + K_W'(1);
              acc_r <= acc_next_s;
            end
          end
        end
        ST_DONE: begin
          cnt_r <= 16'd0;
        end
        default: begin
          cnt_r <= 16'd0;
          k_r   <= '0;
          acc_r <= '0;
        end
      endcase
    end
  end

  // Single-entry output register; a completing beat can refill it in the
  // same cycle the previous word is taken, keeping pack_val high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_bus  <= '0;
      pack_last <= 1'b0;
      pack_val  <= 1'b0;
    end else if (beat_fire_s && completes_s) begin
      pack_bus  <= acc_next_s;
      pack_last <= last_beat_s;
      pack_val  <= 1'b1;
    end else if (pack_rdy) begin
      pack_val  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_pack.sv
// Self-checking bench for result_pack: directed steps from the test plan plus
// randomized traffic, all checked against a frame-level reference model.
module tb_result_pack;

  localparam int BW = 16;
  localparam int PN = 4;
  localparam int PW = 64;
  localparam logic [4:0] CFG_A = 5'd12;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cfg_data;
  logic [4:0]    cfg_addr;
  logic          cfg_valid;
  logic [BW-1:0] result_bus;
  logic          result_val;
  logic          result_rdy;
  logic [PW-1:0] pack_bus;
  logic          pack_last;
  logic          pack_val;
  logic          pack_rdy;

  always #5 clk = ~clk;

  result_pack #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .DEPTH_NB(1), .IMG_WIDTH(BW),
    .PACK_NB(PN), .CFG_RESULT(CFG_A)
  ) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .result_bus(result_bus), .result_val(result_val),
    .result_rdy(result_rdy), .pack_bus(pack_bus), .pack_last(pack_last),
    .pack_val(pack_val), .pack_rdy(pack_rdy)
  );

  int total = 0;
  int bad = 0;

  // Reference model: frame mode (0 idle, 1 taking beats, 2 one-cycle wrap-up)
  int            m_mode, m_n, m_rep, m_cnt, m_lane;
  logic [BW-1:0] m_lanes [PN];
  logic [PW-1:0] q_word [$];
  bit            q_last [$];
  int            words_seen = 0;
  int            last_seen = 0;
  int            beats_acc = 0;
  bit            f;
  int            w0, l0, b0, v;

  function automatic logic [PW-1:0] build_word(int nfill);
    logic [PW-1:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < nfill; i++) begin
`ifdef RESULT_PACK_MSB_FIRST_EN
      idx = PN - 1 - i;
`else
      idx = i;
`endif
      w[idx*BW +: BW] = m_lanes[i];
    end
    return w;
  endfunction

  task automatic chk(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, take the edge.
  task automatic tick(output bit fired);
    bit comp, exp_rdy;
    #1;
    comp    = (m_lane == PN - 1) || (m_cnt == m_n - 1);
    exp_rdy = (m_mode == 1) && (!comp || q_word.size() == 0 || pack_rdy);
    chk("result_rdy", PW'(result_rdy), PW'(exp_rdy));
    chk("pack_val", PW'(pack_val), PW'(q_word.size() != 0));
    if (q_word.size() != 0) begin
      chk("pack_bus", pack_bus, q_word[0]);
      chk("pack_last", PW'(pack_last), PW'(q_last[0]));
    end
    if (q_word.size() != 0 && pack_rdy) begin
      if (q_last[0]) last_seen++;
      words_seen++;
      void'(q_word.pop_front());
      void'(q_last.pop_front());
    end
    fired = 1'b0;
    if (m_mode == 0) begin
      if (cfg_valid && cfg_addr == CFG_A && cfg_data[15:0] != 16'd0) begin
        m_n = int'(cfg_data[15:0]); m_rep = int'(cfg_data[16]);
        m_cnt = 0; m_lane = 0; m_mode = 1;
      end
    end else if (m_mode == 2) begin
      m_mode = (m_rep != 0) ? 1 : 0;
      m_cnt = 0;
    end else if (result_val && exp_rdy) begin
      fired = 1'b1;
      beats_acc++;
      m_lanes[m_lane] = result_bus;
      m_lane++; m_cnt++;
      if (m_lane == PN || m_cnt == m_n) begin
        q_word.push_back(build_word(m_lane));
        q_last.push_back(m_cnt == m_n);
        m_lane = 0;
        if (m_cnt == m_n) m_mode = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; result_val = 1'b0; cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 0; m_n = 0; m_rep = 0; m_cnt = 0; m_lane = 0;
    q_word.delete(); q_last.delete();
    #1;
    chk("rst_result_rdy", PW'(result_rdy), '0);
    chk("rst_pack_val", PW'(pack_val), '0);
    chk("rst_pack_last", PW'(pack_last), '0);
    chk("rst_pack_bus", pack_bus, '0);
  endtask

  task automatic cfg_write(int n, int rep);
    bit ff;
    cfg_data = {15'd0, rep[0], n[15:0]};
    cfg_addr = CFG_A;
    cfg_valid = 1'b1;
    tick(ff);
    cfg_valid = 1'b0;
  endtask

  task automatic send(int val);
    bit ff;
    result_val = 1'b1;
    result_bus = val[BW-1:0];
    ff = 1'b0;
    for (int i = 0; i < 20 && !ff; i++) tick(ff);
    chk("send_accept", PW'(ff), PW'(1));
    result_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_data = 32'd0; cfg_addr = 5'd0; cfg_valid = 1'b0;
    result_bus = '0; result_val = 1'b0; pack_rdy = 1'b1;
    do_reset();

    // Basic packing (MSB build: N=3 exercises the padded reversed word)
    pack_rdy = 1'b1;
`ifdef RESULT_PACK_MSB_FIRST_EN
    cfg_write(3, 0);
    for (int i = 1; i <= 3; i++) send(i);
    chk("msb_word", pack_bus, {16'd1, 16'd2, 16'd3, 16'd0});
`else
    cfg_write(4, 0);
    for (int i = 1; i <= 4; i++) send(i);
    chk("basic_word", pack_bus, {16'd4, 16'd3, 16'd2, 16'd1});
`endif
    chk("basic_last", PW'(pack_last), PW'(1));
    for (int i = 0; i < 3; i++) tick(f);

    // Partial final word
    cfg_write(6, 0);
    for (int i = 1; i <= 6; i++) send(i);
    for (int i = 0; i < 3; i++) tick(f);

    // Backpressure: the second completing beat must stall
    pack_rdy = 1'b0;
    cfg_write(8, 0);
    b0 = beats_acc; w0 = words_seen;
    v = 1; result_val = 1'b1;
    for (int i = 0; i < 12; i++) begin
      result_bus = v[BW-1:0];
      tick(f);
      if (f) v++;
    end
    chk("bp_stalled_beats", PW'(beats_acc - b0), PW'(7));
    pack_rdy = 1'b1;
    for (int i = 0; i < 20 && v <= 8; i++) begin
      result_bus = v[BW-1:0];
      tick(f);
      if (f) v++;
    end
    result_val = 1'b0;
    for (int i = 0; i < 4; i++) tick(f);
    chk("bp_words", PW'(words_seen - w0), PW'(2));

    // Repeat mode with an ignored config write while active
    w0 = words_seen; l0 = last_seen;
    cfg_write(2, 1);
    for (int i = 1; i <= 3; i++) send(i);
    cfg_write(5, 0);
    for (int i = 4; i <= 6; i++) send(i);
    for (int i = 0; i < 3; i++) tick(f);
    chk("rep_words", PW'(words_seen - w0), PW'(3));
    chk("rep_lasts", PW'(last_seen - l0), PW'(3));
    do_reset();

    // Reset mid-frame discards the partial word
    cfg_write(4, 0);
    send(7); send(8);
    do_reset();
    w0 = words_seen;
    cfg_write(4, 0);
    for (int i = 9; i <= 12; i++) send(i);
    for (int i = 0; i < 3; i++) tick(f);
    chk("rst_mid_words", PW'(words_seen - w0), PW'(1));

    // Randomized traffic, config noise and backpressure
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < 60; c++) begin
        cfg_valid  = ($urandom % 8) == 0;
        cfg_addr   = ($urandom % 2 == 0) ? CFG_A : 5'($urandom);
        cfg_data   = {15'd0, 1'($urandom), 16'($urandom_range(0, 10))};
        result_val = ($urandom % 4) != 0;
        result_bus = 16'($urandom);
        pack_rdy   = ($urandom % 3) != 0;
        tick(f);
      end
      cfg_valid = 1'b0; result_val = 1'b0; pack_rdy = 1'b1;
      for (int i = 0; i < 3; i++) tick(f);
      do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
